vm_change_dispenser: RTL and testbench
======================================

// Module: vm_change_dispenser
// PURPOSE
//  Sequential stage downstream of the vending-machine merchant logic. Accepts the
//  one-hot-per-denomination return-coin mask, tracks per-denomination coin stock,
//  and ejects coins to the physical hopper one per valid/ready handshake, highest
//  denomination first. Reports completion, shortfall (coin owed but out of stock) and stock.
// PARAMETERS
//  NUM_COINS      `kNumCoins  number of coin denominations (index = coin_value index)
//  CNT_BITS       8           width of each per-denomination stock counter
//  INIT_STOCK     10          stock loaded into every counter at reset
//  REFILL_AMOUNT  10          coins added per refill pulse for a denomination
//  TIMEOUT_CYCLES 16          hopper-ready timeout (used only with VM_EJECT_TIMEOUT_EN)
// PORTS
//  clk            in   1                    system clock, rising edge
//  reset_n        in   1                    asynchronous active-low reset
//  i_return_req   in   1                    request valid; mask on i_return_coin
//  i_return_coin  in   NUM_COINS            coins to return (bit i = one coin_value[i])
//  o_req_ready    out  1                    high only in IDLE; request accepted when both high
//  o_eject_valid  out  1                    coin on o_eject_coin awaiting hopper
//  o_eject_coin   out  NUM_COINS            one-hot denomination being ejected
//  i_eject_ready  in   1                    hopper accepts coin this cycle
//  i_refill_coin  in   NUM_COINS            one-cycle pulse per bit: add REFILL_AMOUNT
//  o_done         out  1                    one-cycle pulse when a request finishes
//  o_busy         out  1                    high in any state other than IDLE
//  o_shortfall    out  NUM_COINS            sticky: bit i set if coin i owed with stock 0
//  o_stock        out  NUM_COINS*CNT_BITS   packed counters, coin i at [i*CNT_BITS +: CNT_BITS]
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE, pending=0, o_eject_valid=0, o_eject_coin=0,
//    o_done=0, o_busy=0, o_shortfall=0, every stock=INIT_STOCK. Reset mid-eject drops pending.
//  - FSM IDLE -> EJECT -> DONE -> IDLE. All outputs registered or decoded from state only.
//  - IDLE: o_req_ready=1. On i_return_req: latch mask into pending, go EJECT next cycle.
//    Empty mask still goes to EJECT, which sees pending=0 and goes to DONE.
//  - EJECT: idx = highest set bit of pending.
//    stock[idx]==0: set o_shortfall[idx], clear pending[idx], no valid, 1 cycle per skip.
//    Otherwise assert o_eject_valid with o_eject_coin=1<<idx. Hold coin and valid stable until
//    i_eject_ready. On the handshake cycle decrement stock[idx] and clear pending[idx].
//    Next coin's valid is presented the cycle after. pending==0 -> DONE.
//  - DONE: o_done=1 for exactly one cycle, then IDLE. Min latency from accept to o_done for
//    k coins with ready tied high: k+2 cycles.
//  - Refill: stock[i] += REFILL_AMOUNT, saturating at 2^CNT_BITS-1. Refill and handshake decrement
//    on the same coin in the same cycle give stock + REFILL_AMOUNT - 1, saturated.
//    Refill does not clear o_shortfall. o_shortfall clears only on reset.
//  - i_eject_ready is ignored while o_eject_valid=0. i_return_req is ignored while o_req_ready=0.
// CONFIGURATION
//  VM_EJECT_TIMEOUT_EN defined: a counter runs while o_eject_valid=1 && !i_eject_ready.
//    At TIMEOUT_CYCLES it drops valid, sets o_shortfall[idx], clears pending[idx], does not
//    decrement stock, and resumes with the next coin. The counter resets on every new coin.
//  Undefined: no counter; valid is held indefinitely until ready.
// STRUCTURE
//  - Constants kNumCoins/kTotalBits and state encodings (IDLE/EJECT/DONE) go in the shared
//    vending_machine_def.v include.
//  - One sub-module, vm_coin_stock: holds NUM_COINS saturating counters with refill/decrement
//    ports. The FSM and priority select stay in vm_change_dispenser.
// TESTING
//  1. Reset, then req mask 3'b101, ready tied 1 -> ejects 3'b100 then 3'b001 on consecutive
//     valid cycles. o_done 4 cycles after accept. Stocks {9,10,9}.
//  2. Req 3'b010, ready low 5 cycles -> valid and coin 3'b010 held stable all 5 cycles.
//     Stock[1] drops 10->9 only on the ready cycle.
//  3. Drain stock[2] to 0, then req 3'b110 -> o_shortfall[2]=1, only 3'b010 ejected, o_done pulses.
//  4. Req 3'b000 -> no valid. o_done exactly 2 cycles after accept.
//  5. Refill coin 0 at 250 with CNT_BITS=8 -> saturates at 255. Refill and eject coin 0 in the
//     same cycle from 10 -> 19.
//  6. reset_n low mid-EJECT -> outputs return to reset values immediately. Request not resumed.
//     With VM_EJECT_TIMEOUT_EN: ready held 0 -> valid drops after 16 cycles, shortfall set.

Source files
------------

// File: rtl/vm_change_dispenser_pkg.sv
// Shared constants and FSM encoding for the change dispenser slice.
// Latency: n/a. Backpressure: n/a.
// Build option VM_EJECT_TIMEOUT_EN is consumed by vm_change_dispenser only.
package vm_change_dispenser_pkg;

    localparam int kNumCoins  = 3;
    localparam int kCntBits   = 8;
    localparam int kTotalBits = kNumCoins * kCntBits;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EJECT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/vm_change_dispenser_coin_stock.sv
// Per-denomination saturating coin stock counters with refill and decrement.
// Latency: updates visible 1 cycle after refill/decrement. Backpressure: none.
module vm_coin_stock #(
    parameter int NUM_COINS     = 3,
    parameter int CNT_BITS      = 8,
    parameter int INIT_STOCK    = 10,
    parameter int REFILL_AMOUNT = 10
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_COINS-1:0]          i_refill,
    input  logic [NUM_COINS-1:0]          i_dec,
    output logic [NUM_COINS*CNT_BITS-1:0] o_stock
);

    localparam logic [CNT_BITS:0]   REFILL_W = (CNT_BITS+1)'(REFILL_AMOUNT);
    localparam logic [CNT_BITS:0]   CNT_MAX  = {1'b0, {CNT_BITS{1'b1}}};
    localparam logic [CNT_BITS-1:0] INIT_W   = CNT_BITS'(INIT_STOCK);

    logic [CNT_BITS-1:0] cnt_q [NUM_COINS];
    logic [CNT_BITS-1:0] cnt_d [NUM_COINS];
    logic [CNT_BITS:0]   sum;

    // One extra bit of headroom so refill overflow is seen before saturating.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            sum = {1'b0, cnt_q[i]};
            if (i_refill[i]) sum = sum + REFILL_W;
            if (i_dec[i] && cnt_q[i] != '0) sum = sum - 1'b1;
            cnt_d[i] = (sum > CNT_MAX) ? {CNT_BITS{1'b1}} : sum[CNT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_COINS; i++) cnt_q[i] <= INIT_W;
        end else begin
            for (int i = 0; i < NUM_COINS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        o_stock = '0;
        for (int i = 0; i < NUM_COINS; i++) o_stock[i*CNT_BITS +: CNT_BITS] = cnt_q[i];
    end

endmodule

// File: rtl/vm_change_dispenser.sv
// Ejects a return-coin mask one coin per valid/ready handshake, highest denomination first.
// Latency: accept to o_done = k+2 cycles for k coins with ready high; out-of-stock coins cost 1 cycle.
// Backpressure: coin held until i_eject_ready; VM_EJECT_TIMEOUT_EN abandons a coin after TIMEOUT_CYCLES.
module vm_change_dispenser
    import vm_change_dispenser_pkg::*;
#(
    parameter int NUM_COINS      = kNumCoins,
    parameter int CNT_BITS       = kCntBits,
    parameter int INIT_STOCK     = 10,
    parameter int REFILL_AMOUNT  = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_return_req,
    input  logic [NUM_COINS-1:0]          i_return_coin,
    output logic                          o_req_ready,
    output logic                          o_eject_valid,
    output logic [NUM_COINS-1:0]          o_eject_coin,
    input  logic                          i_eject_ready,
    input  logic [NUM_COINS-1:0]          i_refill_coin,
    output logic                          o_done,
    output logic                          o_busy,
    output logic [NUM_COINS-1:0]          o_shortfall,
    output logic [NUM_COINS*CNT_BITS-1:0] o_stock
);

    state_e                        state_q, state_d;
    logic [NUM_COINS-1:0]          pending_q, pending_d;
    logic                          valid_q, valid_d;
    logic [NUM_COINS-1:0]          coin_q, coin_d;
    logic [NUM_COINS-1:0]          shortfall_q, shortfall_d;
    logic [NUM_COINS-1:0]          dec, pend_eff, sel_oh;
    logic                          sel_empty, advance, drop;
    logic [NUM_COINS*CNT_BITS-1:0] stock_w;

`ifdef VM_EJECT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    vm_coin_stock #(
        .NUM_COINS    (NUM_COINS),
        .CNT_BITS     (CNT_BITS),
        .INIT_STOCK   (INIT_STOCK),
        .REFILL_AMOUNT(REFILL_AMOUNT)
    ) u_stock (
        .clk     (clk),
        .reset_n (reset_n),
        .i_refill(i_refill_coin),
        .i_dec   (dec),
        .o_stock (stock_w)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        valid_d     = valid_q;
        coin_d      = coin_q;
        shortfall_d = shortfall_q;
        dec         = '0;
        pend_eff    = pending_q;
        sel_oh      = '0;
        sel_empty   = 1'b0;
        drop        = 1'b0;
`ifdef VM_EJECT_TIMEOUT_EN
        drop = valid_q && !i_eject_ready && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif
        if (valid_q && i_eject_ready) begin
            dec      = coin_q;
            pend_eff = pending_q & ~coin_q;
        end else if (drop) begin
            pend_eff = pending_q & ~coin_q;
        end
        advance = !valid_q || i_eject_ready || drop;
        // Ascending scan: the last hit is the highest remaining denomination.
        for (int i = 0; i < NUM_COINS; i++) begin
            if (pend_eff[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_empty = (stock_w[i*CNT_BITS +: CNT_BITS] == '0);
            end
        end
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                coin_d  = '0;
                if (i_return_req) begin
                    pending_d = i_return_coin;
                    state_d   = ST_EJECT;
                end
            end
            ST_EJECT: begin
                if (advance) begin
                    if (drop) shortfall_d = shortfall_d | coin_q;
                    valid_d   = 1'b0;
                    coin_d    = '0;
                    pending_d = pend_eff;
                    if (sel_oh == '0) begin
                        state_d = ST_DONE;
                    end else if (sel_empty) begin
                        shortfall_d = shortfall_d | sel_oh;
                        pending_d   = pend_eff & ~sel_oh;
                    end else begin
                        valid_d = 1'b1;
                        coin_d  = sel_oh;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef VM_EJECT_TIMEOUT_EN
    always_comb begin
        tmo_d = tmo_q;
        if (state_q != ST_EJECT || advance) tmo_d = '0;
        else if (valid_q) tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tmo_q <= '0;
        else          tmo_q <= tmo_d;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            valid_q     <= 1'b0;
            coin_q      <= '0;
            shortfall_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            valid_q     <= valid_d;
            coin_q      <= coin_d;
            shortfall_q <= shortfall_d;
        end
    end

    assign o_req_ready   = (state_q == ST_IDLE);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = (state_q == ST_DONE);
    assign o_eject_valid = valid_q;
    assign o_eject_coin  = coin_q;
    assign o_shortfall   = shortfall_q;
    assign o_stock       = stock_w;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Bench for vm_change_dispenser: request table plus hold, refill, reset and timeout sequences.
module tb_vm_change_dispenser;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_return_req;
    logic [2:0]  i_return_coin;
    logic        o_req_ready;
    logic        o_eject_valid;
    logic [2:0]  o_eject_coin;
    logic        i_eject_ready;
    logic [2:0]  i_refill_coin;
    logic        o_done;
    logic        o_busy;
    logic [2:0]  o_shortfall;
    logic [23:0] o_stock;

    always #5 clk = ~clk;

    vm_change_dispenser dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_return_req (i_return_req),
        .i_return_coin(i_return_coin),
        .o_req_ready  (o_req_ready),
        .o_eject_valid(o_eject_valid),
        .o_eject_coin (o_eject_coin),
        .i_eject_ready(i_eject_ready),
        .i_refill_coin(i_refill_coin),
        .o_done       (o_done),
        .o_busy       (o_busy),
        .o_shortfall  (o_shortfall),
        .o_stock      (o_stock)
    );

    typedef struct {
        logic [2:0] mask;
        int         reps;
        int         exp_lat;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] exp_q[$];
    int         ms[3];
    logic [2:0] msf;
    logic       s_done;
    vec_t       vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sample at negedge (scoreboard pop on handshake), then advance to posedge+1 for driving.
    task automatic cyc();
        logic [2:0] e;
        @(negedge clk);
        s_done = o_done;
        if (o_eject_valid && i_eject_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_eject", {31'd0, o_eject_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("eject_coin", {29'd0, o_eject_coin}, {29'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) ms[i] = 10;
        msf = 3'b000;
        exp_q.delete();
    endtask

    task automatic chk_stocks();
        for (int i = 0; i < 3; i++) chk("stock", {24'd0, o_stock[i*8 +: 8]}, ms[i]);
    endtask

    task automatic chk_reset_vals();
        chk("rst_valid", o_eject_valid, 0);
        chk("rst_coin", o_eject_coin, 0);
        chk("rst_done", o_done, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_req_ready", o_req_ready, 1);
        chk("rst_shortfall", o_shortfall, 0);
        chk_stocks();
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        model_reset();
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic start_req(input logic [2:0] mask);
        for (int i = 2; i >= 0; i--) begin
            if (mask[i]) begin
                if (ms[i] == 0) msf[i] = 1'b1;
                else begin
                    exp_q.push_back(3'b001 << i);
                    ms[i] = ms[i] - 1;
                end
            end
        end
        chk("req_ready_idle", o_req_ready, 1);
        i_return_req  = 1'b1;
        i_return_coin = mask;
        cyc();
        i_return_req  = 1'b0;
        i_return_coin = 3'b000;
    endtask

    task automatic wait_done(input int exp_lat);
        int lat;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            cyc();
            if (s_done) begin
                lat = k;
                break;
            end
        end
        chk("done_seen", s_done, 1);
        if (exp_lat > 0) chk("done_latency", lat, exp_lat);
        cyc();
        chk("done_pulse_width", s_done, 0);
        chk("req_ready_after", o_req_ready, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("shortfall", o_shortfall, msf);
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 20; k++) begin
            if (o_eject_valid) break;
            cyc();
        end
        chk("valid_seen", o_eject_valid, 1);
    endtask

    task automatic refill(input logic [2:0] mask);
        i_refill_coin = mask;
        for (int i = 0; i < 3; i++)
            if (mask[i]) ms[i] = (ms[i] + 10 > 255) ? 255 : ms[i] + 10;
        cyc();
        i_refill_coin = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'b101, 1, 4};
        vecs[1] = '{3'b000, 1, 2};
        vecs[2] = '{3'b111, 1, 5};
        vecs[3] = '{3'b010, 1, 3};
        vecs[4] = '{3'b100, 8, 3};   // drains coin 2 to zero
        vecs[5] = '{3'b110, 1, 4};
        vecs[6] = '{3'b100, 1, 3};
        vecs[7] = '{3'b011, 1, 4};

        reset_n       = 1'b0;
        i_return_req  = 1'b0;
        i_return_coin = 3'b000;
        i_eject_ready = 1'b1;
        i_refill_coin = 3'b000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        reset_n = 1'b1;
        cyc();

        foreach (vecs[v]) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                start_req(vecs[v].mask);
                wait_done(vecs[v].exp_lat);
                chk_stocks();
            end
        end

        // Backpressure: coin and valid stable while the hopper stalls.
        i_eject_ready = 1'b0;
        start_req(3'b010);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", o_eject_valid, 1);
            chk("hold_coin", o_eject_coin, 3'b010);
            chk("hold_stock", {24'd0, o_stock[15:8]}, ms[1] + 1);
            cyc();
        end
        i_eject_ready = 1'b1;
        cyc();
        wait_done(-1);
        chk_stocks();

        // Refill saturation on coin 0.
        for (int k = 0; k < 24; k++) refill(3'b001);
        chk("refill_stock0", {24'd0, o_stock[7:0]}, ms[0]);
        refill(3'b001);
        chk("refill_sat", {24'd0, o_stock[7:0]}, ms[0]);
        refill(3'b001);
        chk("refill_sat_hold", {24'd0, o_stock[7:0]}, ms[0]);

        // Refill and handshake on the same coin in the same cycle.
        reset_dut();
        chk_reset_vals();
        i_eject_ready = 1'b0;
        start_req(3'b001);
        wait_valid();
        i_eject_ready = 1'b1;
        i_refill_coin = 3'b001;
        ms[0] = ms[0] + 10;
        cyc();
        i_refill_coin = 3'b000;
        wait_done(-1);
        chk("refill_and_eject", {24'd0, o_stock[7:0]}, 19);
        chk_stocks();

        // Reset in the middle of an eject.
        i_eject_ready = 1'b0;
        start_req(3'b010);
        wait_valid();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_reset_vals();
        i_eject_ready = 1'b1;
        cyc();
        cyc();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("no_resume_busy", o_busy, 0);
        end
        chk_stocks();

`ifdef VM_EJECT_TIMEOUT_EN
        begin
            int vcnt;
            vcnt = 0;
            i_eject_ready = 1'b0;
            start_req(3'b010);
            exp_q.delete();
            ms[1] = ms[1] + 1;
            msf[1] = 1'b1;
            wait_valid();
            for (int k = 0; k < 40; k++) begin
                if (!o_eject_valid) break;
                vcnt++;
                cyc();
            end
            chk("timeout_valid_cycles", vcnt, 16);
            wait_done(-1);
            chk_stocks();
            i_eject_ready = 1'b1;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
